// File: rtl/line_mem_arbiter_if.sv
// rtl/line_mem_arbiter_if.sv - bus bundle between line_mem_arbiter and its environment
//
// Purpose: groups the frame/write/read request inputs, the shared SRAM port-A
// address/enable bus and the read-return/status outputs of line_mem_arbiter.
// Modports:
//   slave  - the arbiter side (requests and SRAM read data in, bus and status out)
//   master - the environment side (line writer, gravity reader, SRAM banks)
// Signals:
//   iFVAL, iWR_REQ, iWR_ROW          frame valid and line-write request
//   iRD_REQ, iRD_ADDR                read request (held until granted) and row
//   iMEMOUT_A, iMEMOUT_B             bank A / B port-A read data
//   oMEM_ADDR, oMEM_EN*, oMEM_WE*    shared port-A address and bank strobes
//   oWR_BANK, oRD_BANK               bank being written / holding last frame
//   oRD_GNT, oRD_VALID, oRD_DATA     read issue strobe and registered return
//   oFRAME_AVAIL, oFRAME_DONE        completed frame exists / swap pulse
//   oFRAME_LINES, oDROP              lines in last frame / sticky drop flag

interface line_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 640
);
  logic                  iFVAL;
  logic                  iWR_REQ;
  logic [ADDR_WIDTH-1:0] iWR_ROW;
  logic                  iRD_REQ;
  logic [ADDR_WIDTH-1:0] iRD_ADDR;
  logic [DATA_WIDTH-1:0] iMEMOUT_A;
  logic [DATA_WIDTH-1:0] iMEMOUT_B;
  logic [ADDR_WIDTH-1:0] oMEM_ADDR;
  logic                  oMEM_ENA;
  logic                  oMEM_ENB;
  logic                  oMEM_WEA;
  logic                  oMEM_WEB;
  logic                  oWR_BANK;
  logic                  oRD_BANK;
  logic                  oRD_GNT;
  logic                  oRD_VALID;
  logic [DATA_WIDTH-1:0] oRD_DATA;
  logic                  oFRAME_AVAIL;
  logic                  oFRAME_DONE;
  logic [ADDR_WIDTH-1:0] oFRAME_LINES;
  logic                  oDROP;

  modport slave (
    input  iFVAL, iWR_REQ, iWR_ROW, iRD_REQ, iRD_ADDR, iMEMOUT_A, iMEMOUT_B,
    output oMEM_ADDR, oMEM_ENA, oMEM_ENB, oMEM_WEA, oMEM_WEB,
    output oWR_BANK, oRD_BANK, oRD_GNT, oRD_VALID, oRD_DATA,
    output oFRAME_AVAIL, oFRAME_DONE, oFRAME_LINES, oDROP
  );

  modport master (
    output iFVAL, iWR_REQ, iWR_ROW, iRD_REQ, iRD_ADDR, iMEMOUT_A, iMEMOUT_B,
    input  oMEM_ADDR, oMEM_ENA, oMEM_ENB, oMEM_WEA, oMEM_WEB,
    input  oWR_BANK, oRD_BANK, oRD_GNT, oRD_VALID, oRD_DATA,
    input  oFRAME_AVAIL, oFRAME_DONE, oFRAME_LINES, oDROP
  );
endinterface

// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - ping-pong line memory bank sequencer and port-A arbiter
//
// Purpose: tracks camera frames (IDLE/WRITE/SWAP), selects which of the two
// line-memory banks is written and which holds the last completed frame, and
// multiplexes the single port-A address bus between the line writer (always
// wins) and the gravity reader (granted on free cycles, at most every other
// cycle). Read data is returned from the bank that was current at grant time.
// Ports:
//   CLK    camera clock
//   RST_N  asynchronous active-low reset
//   bus    line_mem_arbiter_if.slave (see the interface file for signal list)

module line_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 640,
  parameter int MAX_ROW    = 480,
  parameter int RD_LATENCY = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  line_mem_arbiter_if.slave      bus
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ROW_A = ADDR_WIDTH'(MAX_ROW);

  typedef enum logic [1:0] {IDLE, WRITE, SWAP} state_t;

  state_t                state;
  logic                  fval_q;
  logic [ADDR_WIDTH-1:0] line_cnt;
  logic                  wr_bank;
  logic                  rd_bank;
  logic                  frame_avail;
  logic                  frame_done;
  logic [ADDR_WIDTH-1:0] frame_lines;
  logic                  drop;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ena;
  logic                  mem_enb;
  logic                  mem_wea;
  logic                  mem_web;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  // vld_sr[0] is the grant strobe itself (address on the bus this cycle);
  // vld_sr[k] marks the read whose data is k cycles further down the SRAM.
  logic [RD_LATENCY:0]   vld_sr;
  logic [RD_LATENCY:0]   tag_sr;

  logic                  fval_rise;
  logic                  wr_ok;
  logic                  gnt_nx;
  logic [ADDR_WIDTH-1:0] cnt_nx;

  assign fval_rise = bus.iFVAL && !fval_q;
  assign wr_ok     = (state == WRITE) && bus.iWR_REQ && (bus.iWR_ROW < MAX_ROW_A);

  // Any write request, even one that ends up dropped, keeps the read off the
  // bus this cycle; the one-cycle gap after a grant lets the reader drop REQ.
  assign gnt_nx    = bus.iRD_REQ && frame_avail && !bus.iWR_REQ && !vld_sr[0];

  // Counter value including a write accepted in this same cycle, so a frame
  // whose last line coincides with the FVAL fall is still counted.
  assign cnt_nx    = (wr_ok && (line_cnt < MAX_ROW_A)) ? line_cnt + ADDR_WIDTH'(1) : line_cnt;

  // Frame sequencer. Bank-swap results become visible in the SWAP cycle itself
  // so that a read granted during SWAP already targets the new read bank; the
  // write bank follows one cycle later from the updated read bank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      fval_q      <= 1'b0;
      line_cnt    <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_avail <= 1'b0;
      frame_done  <= 1'b0;
      frame_lines <= '0;
      drop        <= 1'b0;
    end else begin
      fval_q     <= bus.iFVAL;
      frame_done <= 1'b0;
      if (bus.iWR_REQ && !wr_ok) begin
        drop <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (fval_rise) begin
            state    <= WRITE;
            line_cnt <= '0;
          end
        end
        WRITE: begin
          line_cnt <= cnt_nx;
          if (!bus.iFVAL) begin
            if (cnt_nx != '0) begin
              state       <= SWAP;
              rd_bank     <= wr_bank;
              frame_lines <= cnt_nx;
              frame_avail <= 1'b1;
              frame_done  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        SWAP: begin
          wr_bank  <= ~rd_bank;
          line_cnt <= '0;
          state    <= bus.iFVAL ? WRITE : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Port-A bus and read-return pipeline. Write and read strobes are mutually
  // exclusive because a grant requires no write request in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_addr <= '0;
      mem_ena  <= 1'b0;
      mem_enb  <= 1'b0;
      mem_wea  <= 1'b0;
      mem_web  <= 1'b0;
      vld_sr   <= '0;
      tag_sr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_ok) begin
        mem_addr <= bus.iWR_ROW;
      end else if (gnt_nx) begin
        mem_addr <= bus.iRD_ADDR;
      end
      mem_ena <= (wr_ok && !wr_bank) || (gnt_nx && !rd_bank);
      mem_enb <= (wr_ok &&  wr_bank) || (gnt_nx &&  rd_bank);
      mem_wea <= wr_ok && !wr_bank;
      mem_web <= wr_ok &&  wr_bank;

      vld_sr[0] <= gnt_nx;
      tag_sr[0] <= rd_bank;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end

      rd_valid <= vld_sr[RD_LATENCY];
      if (vld_sr[RD_LATENCY]) begin
        rd_data <= tag_sr[RD_LATENCY] ? bus.iMEMOUT_B : bus.iMEMOUT_A;
      end
    end
  end

  assign bus.oMEM_ADDR    = mem_addr;
  assign bus.oMEM_ENA     = mem_ena;
  assign bus.oMEM_ENB     = mem_enb;
  assign bus.oMEM_WEA     = mem_wea;
  assign bus.oMEM_WEB     = mem_web;
  assign bus.oWR_BANK     = wr_bank;
  assign bus.oRD_BANK     = rd_bank;
  assign bus.oRD_GNT      = vld_sr[0];
  assign bus.oRD_VALID    = rd_valid;
  assign bus.oRD_DATA     = rd_data;
  assign bus.oFRAME_AVAIL = frame_avail;
  assign bus.oFRAME_DONE  = frame_done;
  assign bus.oFRAME_LINES = frame_lines;
  assign bus.oDROP        = drop;

endmodule
